// File: rtl/gpr_pkg.sv
// gpr_pkg: opcode constants and swap FSM state type shared by the register bank
package gpr_pkg;
  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_READ  = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam logic [2:0] OP_MOVE  = 3'b100;
  localparam logic [2:0] OP_SWAP  = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;
  typedef enum logic {IDLE, SWAP2} swap_state_t;
endpackage

// File: rtl/gpr_swap_ctrl.sv
// gpr_swap_ctrl: two-state SWAP sequencer producing the registered busy flag
module gpr_swap_ctrl
  import gpr_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic swap2
);
  swap_state_t state;
  assign swap2 = state == SWAP2;
  // IDLE -> SWAP2 on an accepted SWAP, always back to IDLE afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else if (state == IDLE && start) begin
      state <= SWAP2;
      busy  <= 1'b1;
    end else begin
      state <= IDLE;
      busy  <= 1'b0;
    end
  end
endmodule

// File: rtl/gp_register_bank.sv
// gp_register_bank: register file with ALU/bus ports, 2-cycle SWAP, accumulator port; GPR_BYPASS_EN forwards same-cycle writes to READ/STORE
module gp_register_bank
  import gpr_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_REGS = 8,
  parameter int ACC_IDX = 0,
  localparam int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [2:0]        mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic              alu2in_enable,
  input  logic              acc_enable,
  input  logic [DATA_W-1:0] acc_input,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_out_valid,
  output logic [DATA_W-1:0] alu_1st_in,
  output logic [DATA_W-1:0] alu_2nd_in,
  output logic              busy
);
  localparam logic [ADDR_W-1:0] ACC_A = ADDR_W'(ACC_IDX);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] temp;
  logic [DATA_W-1:0] src_val;
  logic [ADDR_W-1:0] swap_src;
  logic accept;
  logic swap2;
  assign accept = enable && !busy;
`ifdef GPR_BYPASS_EN
  assign src_val = (acc_enable && src_addr == ACC_A) ? acc_input :
                   (swap2 && src_addr == swap_src) ? temp : regs[src_addr];
`else
  assign src_val = regs[src_addr];
`endif
  gpr_swap_ctrl u_swap_ctrl (
    .clk   (clk),
    .reset (reset),
    .start (accept && mode == OP_SWAP),
    .busy  (busy),
    .swap2 (swap2)
  );
  // register array writes; accumulator write is last so it wins any collision
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (accept && mode == OP_LOAD) regs[dst_addr] <= bus_in;
      if (accept && (mode == OP_MOVE || mode == OP_SWAP)) regs[dst_addr] <= regs[src_addr];
      if (accept && mode == OP_CLEAR) regs[dst_addr] <= '0;
      if (swap2) regs[swap_src] <= temp;
      if (acc_enable) regs[ACC_A] <= acc_input;
    end
  end
  // swap holding register, ALU operands and bus output
  always_ff @(posedge clk) begin
    if (reset) begin
      temp          <= '0;
      swap_src      <= '0;
      alu_1st_in    <= '0;
      alu_2nd_in    <= '0;
      bus_out       <= '0;
      bus_out_valid <= 1'b0;
    end else begin
      bus_out_valid <= accept && mode == OP_STORE;
      if (accept && mode == OP_SWAP) begin
        temp     <= regs[dst_addr];
        swap_src <= src_addr;
      end
      if (accept && mode == OP_READ) begin
        alu_1st_in <= src_val;
        if (alu2in_enable) alu_2nd_in <= regs[dst_addr];
      end
      if (accept && mode == OP_STORE) bus_out <= src_val;
    end
  end
endmodule

// File: tb/tb_gp_register_bank.sv
// tb_gp_register_bank: directed self-checking bench for gp_register_bank
module tb_gp_register_bank;
  import gpr_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [2:0] src_addr = '0;
  logic [2:0] dst_addr = '0;
  logic alu2in_enable = 1'b0;
  logic acc_enable = 1'b0;
  logic [15:0] acc_input = '0;
  logic [15:0] bus_in = '0;
  logic [15:0] bus_out;
  logic bus_out_valid;
  logic [15:0] alu_1st_in;
  logic [15:0] alu_2nd_in;
  logic busy;
  logic [15:0] v;
  int n_tests = 0;
  int n_fail = 0;
  gp_register_bank dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .mode          (mode),
    .src_addr      (src_addr),
    .dst_addr      (dst_addr),
    .alu2in_enable (alu2in_enable),
    .acc_enable    (acc_enable),
    .acc_input     (acc_input),
    .bus_in        (bus_in),
    .bus_out       (bus_out),
    .bus_out_valid (bus_out_valid),
    .alu_1st_in    (alu_1st_in),
    .alu_2nd_in    (alu_2nd_in),
    .busy          (busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [2:0] m, input logic [2:0] s, input logic [2:0] d,
                       input logic a2, input logic [15:0] bi);
    enable = 1'b1;
    mode = m;
    src_addr = s;
    dst_addr = d;
    alu2in_enable = a2;
    bus_in = bi;
    tick();
    enable = 1'b0;
    mode = OP_NOP;
    alu2in_enable = 1'b0;
  endtask
  task automatic read_reg(input logic [2:0] idx, output logic [15:0] val);
    issue(OP_STORE, idx, 3'd0, 1'b0, 16'h0);
    val = bus_out;
  endtask
  initial begin
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_valid", bus_out_valid, 0);
    check("rst_bus_out", bus_out, 0);
    check("rst_alu1", alu_1st_in, 0);
    check("rst_alu2", alu_2nd_in, 0);
    issue(OP_LOAD, 3'd0, 3'd3, 1'b0, 16'h1234);
    issue(OP_READ, 3'd3, 3'd3, 1'b1, 16'h0);
    check("read_alu1", alu_1st_in, 16'h1234);
    check("read_alu2", alu_2nd_in, 16'h1234);
    issue(OP_READ, 3'd0, 3'd5, 1'b0, 16'h0);
    check("read_noa2_alu1", alu_1st_in, 16'h0000);
    check("read_noa2_alu2", alu_2nd_in, 16'h1234);
    issue(OP_STORE, 3'd3, 3'd0, 1'b0, 16'h0);
    check("store_data", bus_out, 16'h1234);
    check("store_valid", bus_out_valid, 1);
    tick();
    check("store_valid_drop", bus_out_valid, 0);
    check("store_hold", bus_out, 16'h1234);
    issue(OP_LOAD, 3'd0, 3'd1, 1'b0, 16'h00AA);
    issue(OP_LOAD, 3'd0, 3'd2, 1'b0, 16'h5500);
    issue(OP_SWAP, 3'd1, 3'd2, 1'b0, 16'h0);
    check("swap_busy", busy, 1);
    issue(OP_LOAD, 3'd0, 3'd1, 1'b0, 16'h9999);
    check("swap_busy_done", busy, 0);
    read_reg(3'd1, v);
    check("swap_r1", v, 16'h5500);
    read_reg(3'd2, v);
    check("swap_r2", v, 16'h00AA);
    issue(OP_MOVE, 3'd1, 3'd4, 1'b0, 16'h0);
    issue(OP_CLEAR, 3'd0, 3'd1, 1'b0, 16'h0);
    read_reg(3'd4, v);
    check("move_r4", v, 16'h5500);
    read_reg(3'd1, v);
    check("clear_r1", v, 16'h0000);
    acc_enable = 1'b1;
    acc_input = 16'hFFFF;
    issue(OP_LOAD, 3'd0, 3'd0, 1'b0, 16'h4321);
    acc_enable = 1'b0;
    read_reg(3'd0, v);
    check("acc_beats_load", v, 16'hFFFF);
    issue(OP_SWAP, 3'd0, 3'd5, 1'b0, 16'h0);
    acc_enable = 1'b1;
    acc_input = 16'h7777;
    tick();
    acc_enable = 1'b0;
    read_reg(3'd0, v);
    check("acc_beats_swap2", v, 16'h7777);
    read_reg(3'd5, v);
    check("swap_acc_r5", v, 16'hFFFF);
    issue(OP_SWAP, 3'd3, 3'd3, 1'b0, 16'h0);
    check("self_swap_busy", busy, 1);
    tick();
    check("self_swap_idle", busy, 0);
    read_reg(3'd3, v);
    check("self_swap_r3", v, 16'h1234);
    acc_enable = 1'b1;
    acc_input = 16'hBEEF;
    issue(OP_READ, 3'd0, 3'd0, 1'b0, 16'h0);
    acc_enable = 1'b0;
`ifdef GPR_BYPASS_EN
    check("bypass_read", alu_1st_in, 16'hBEEF);
`else
    check("bypass_read", alu_1st_in, 16'h7777);
`endif
    read_reg(3'd0, v);
    check("acc_r0", v, 16'hBEEF);
    issue(OP_SWAP, 3'd3, 3'd4, 1'b0, 16'h0);
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_swap2_busy", busy, 0);
    check("reset_swap2_alu1", alu_1st_in, 0);
    read_reg(3'd3, v);
    check("reset_r3", v, 0);
    read_reg(3'd4, v);
    check("reset_r4", v, 0);
    read_reg(3'd0, v);
    check("reset_r0", v, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gp_register_bank.md
GP_REGISTER_BANK -- requirements
Module: gp_register_bank

Interface
REQ-001 Parameter DATA_W, default 16: register and data-path width in bits.
REQ-002 Parameter NUM_REGS, default 8: number of registers (power of two, at least 2).
REQ-003 Parameter ACC_IDX, default 0: index of the register written by the accumulator port.
REQ-004 Derived constant ADDR_W = log2(NUM_REGS).
REQ-005 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-006 Port reset, input, 1: reset, synchronous and active-high.
REQ-007 Port enable, input, 1: command strobe; a command is accepted when enable=1 and busy=0.
REQ-008 Port mode, input, 3: command opcode (see Function).
REQ-009 Port src_addr, input, ADDR_W: source register index.
REQ-010 Port dst_addr, input, ADDR_W: destination register index.
REQ-011 Port alu2in_enable, input, 1: allows alu_2nd_in to update on READ.
REQ-012 Port acc_enable, input, 1: accumulator write strobe, independent of enable.
REQ-013 Port acc_input, input, DATA_W: accumulator write data.
REQ-014 Port bus_in, input, DATA_W: load data from the bus.
REQ-015 Port bus_out, output, DATA_W: store data to the bus.
REQ-016 Port bus_out_valid, output, 1: bus_out is valid this cycle.
REQ-017 Port alu_1st_in, output, DATA_W: registered ALU operand A.
REQ-018 Port alu_2nd_in, output, DATA_W: registered ALU operand B.
REQ-019 Port busy, output, 1: a multi-cycle command is in progress.

Function
REQ-020 Opcodes SHALL be:
- 000 NOP.
- 001 READ: alu_1st_in<=R[src]; if alu2in_enable=1, alu_2nd_in<=R[dst], otherwise alu_2nd_in holds.
- 010 LOAD: R[dst]<=bus_in.
- 011 STORE: bus_out<=R[src]; bus_out_valid=1 for exactly one cycle.
- 100 MOVE: R[dst]<=R[src].
- 101 SWAP: R[src] and R[dst] exchange values.
- 110 CLEAR: R[dst]<=0.
- 111 reserved, treated as NOP.
REQ-021 READ, LOAD, STORE, MOVE and CLEAR SHALL complete in one cycle; results SHALL be visible on the cycle after acceptance.
REQ-022 SWAP SHALL use a two-state FSM, IDLE -> SWAP2 -> IDLE.
- Accept cycle: temp<=R[dst]; R[dst]<=R[src]; busy=1 next cycle.
- SWAP2: R[src]<=temp; busy=0 next cycle.
REQ-023 SWAP with src_addr==dst_addr SHALL leave the register unchanged and still take two cycles.
REQ-024 While busy=1, enable SHALL be ignored; the command is dropped, not queued.
REQ-025 acc_enable=1 SHALL write R[ACC_IDX]<=acc_input in any state, including while busy.
REQ-026 When acc_enable and a command write target the same register in the same cycle, the acc_enable write SHALL win.
REQ-027 When acc_enable and SWAP2 both target ACC_IDX in the same cycle, acc_enable SHALL win.
REQ-028 bus_out SHALL hold its last value when bus_out_valid=0.
REQ-029 Address indices SHALL be used modulo NUM_REGS; no out-of-range accesses can occur.

Reset
REQ-030 reset=1 SHALL clear all registers, temp, alu_1st_in, alu_2nd_in and bus_out to 0, set bus_out_valid=0 and busy=0, and put the FSM in IDLE.
REQ-031 reset SHALL take priority over enable and acc_enable.
REQ-032 Reset during SWAP2 SHALL abort the swap; no partial write survives.

Configuration
REQ-033 Macro GPR_BYPASS_EN SHALL select READ/STORE forwarding behaviour.
- Defined: a READ or STORE whose source register is being written in the same cycle (by acc_enable or SWAP2) SHALL return the new value.
- Undefined: it SHALL return the pre-write value.

Structure
REQ-034 A shared package gpr_pkg SHALL hold the mode opcode constants and the FSM state typedef.
REQ-035 Sub-module gpr_swap_ctrl SHALL implement the SWAP FSM and the busy output; the register array stays in the top module.

Verification
REQ-036 LOAD 0x1234 to R3, then READ src=3 -> alu_1st_in=0x1234 one cycle later.
REQ-037 R1=0x00AA, R2=0x5500, SWAP src=1 dst=2 -> busy=1 for one cycle, then R1=0x5500 and R2=0x00AA; an enable pulse during busy has no effect.
REQ-038 acc_enable=1 with acc_input=0xFFFF together with LOAD 0x4321 to R0 -> R0=0xFFFF.
REQ-039 READ with alu2in_enable=0 -> alu_2nd_in is unchanged; STORE src=3 -> bus_out=0x1234 with bus_out_valid high for exactly one cycle.
REQ-040 reset asserted in SWAP2 -> all registers 0, busy=0 on the next cycle.
REQ-041 With GPR_BYPASS_EN defined, acc write 0xBEEF to R0 plus same-cycle READ src=0 -> 0xBEEF; without the macro -> the old value.
